// File: rtl/add_sub_control_unit.sv
// Multi-cycle fetch/decode/execute controller for the ADD_SUB load/store datapath (ld, sd, add, sub).
// Define ADD_SUB_ADDI_EN to also decode addi; otherwise addi traps as illegal.
module add_sub_control_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  PC_RESET = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [31:0]       IMEM_RDATA,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic [11:0]       immediate,
  output logic              sub,
  output logic              I_type,
  output logic              R_type,
  output logic              WE_RF,
  output logic              WE_MEM,
  output logic              MEM_TO_REG,
  output logic              ILLEGAL
);

  typedef enum logic [1:0] {StFetch, StDecode, StExecute, StTrap} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [11:0]       imm_q;
  logic              sub_q, i_type_q, r_type_q, mem_to_reg_q;
  logic              we_rf_q, we_mem_q, illegal_q;
  logic              legal_q, pend_rf_q, pend_mem_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_ld, is_sd, is_rr, is_addi;

  assign opcode = IMEM_RDATA[6:0];
  assign funct3 = IMEM_RDATA[14:12];
  assign funct7 = IMEM_RDATA[31:25];

  assign is_ld = (opcode == 7'b0000011) && (funct3 == 3'b011);
  assign is_sd = (opcode == 7'b0100011) && (funct3 == 3'b011);
  assign is_rr = (opcode == 7'b0110011) && (funct3 == 3'b000) &&
                 ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
`ifdef ADD_SUB_ADDI_EN
  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
`else
  assign is_addi = 1'b0;
`endif

  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [11:0] dec_imm;
  logic        dec_legal, dec_wr_rf;

  // Fields not used by the decoded instruction are forced to zero.
  always_comb begin
    dec_rs1   = (is_ld || is_sd || is_rr || is_addi) ? IMEM_RDATA[19:15] : 5'd0;
    dec_rs2   = (is_sd || is_rr) ? IMEM_RDATA[24:20] : 5'd0;
    dec_rd    = (is_ld || is_rr || is_addi) ? IMEM_RDATA[11:7] : 5'd0;
    dec_imm   = 12'd0;
    if (is_sd) begin
      dec_imm = {IMEM_RDATA[31:25], IMEM_RDATA[11:7]};
    end else if (is_ld || is_addi) begin
      dec_imm = IMEM_RDATA[31:20];
    end
    dec_legal = is_ld || is_sd || is_rr || is_addi;
    // x0 is hardwired, so a write to it is dropped.
    dec_wr_rf = (is_ld || is_rr || is_addi) && (dec_rd != 5'd0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= StFetch;
      pc_q         <= PC_RESET;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      sub_q        <= 1'b0;
      i_type_q     <= 1'b0;
      r_type_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      we_rf_q      <= 1'b0;
      we_mem_q     <= 1'b0;
      illegal_q    <= 1'b0;
      legal_q      <= 1'b0;
      pend_rf_q    <= 1'b0;
      pend_mem_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (IMEM_ACK) begin
            rs1_q        <= dec_rs1;
            rs2_q        <= dec_rs2;
            rd_q         <= dec_rd;
            imm_q        <= dec_imm;
            sub_q        <= is_rr && IMEM_RDATA[30];
            i_type_q     <= is_ld || is_sd || is_addi;
            r_type_q     <= is_rr;
            mem_to_reg_q <= is_ld;
            legal_q      <= dec_legal;
            pend_rf_q    <= dec_wr_rf;
            pend_mem_q   <= is_sd;
            state_q      <= StDecode;
          end
        end
        StDecode: begin
          if (legal_q) begin
            we_rf_q  <= pend_rf_q;
            we_mem_q <= pend_mem_q;
            state_q  <= StExecute;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= StTrap;
          end
        end
        StExecute: begin
          we_rf_q      <= 1'b0;
          we_mem_q     <= 1'b0;
          rs1_q        <= '0;
          rs2_q        <= '0;
          rd_q         <= '0;
          imm_q        <= '0;
          sub_q        <= 1'b0;
          i_type_q     <= 1'b0;
          r_type_q     <= 1'b0;
          mem_to_reg_q <= 1'b0;
          pc_q         <= pc_q + ADDR_W'(4);
          state_q      <= StFetch;
        end
        StTrap: begin
          state_q <= StTrap;
        end
      endcase
    end
  end

  assign IMEM_REQ   = (state_q == StFetch);
  assign IMEM_ADDR  = pc_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign rd         = rd_q;
  assign immediate  = imm_q;
  assign sub        = sub_q;
  assign I_type     = i_type_q;
  assign R_type     = r_type_q;
  assign WE_RF      = we_rf_q;
  assign WE_MEM     = we_mem_q;
  assign MEM_TO_REG = mem_to_reg_q;
  assign ILLEGAL    = illegal_q;

endmodule

// File: tb/tb_add_sub_control_unit.sv
// Self-checking bench for add_sub_control_unit: directed scenarios plus a randomized program run
// checked every cycle against an instruction-level reference model.
module tb_add_sub_control_unit;

  localparam int unsigned       AW  = 32;
  localparam logic [AW-1:0]     PCR = '0;
  localparam int P_FETCH = 0, P_DEC = 1, P_EXE = 2, P_TRAP = 3;

  logic          CLK, RST_N, IMEM_REQ, IMEM_ACK;
  logic [AW-1:0] IMEM_ADDR;
  logic [31:0]   IMEM_RDATA;
  logic [4:0]    rs1, rs2, rd;
  logic [11:0]   immediate;
  logic          sub, I_type, R_type, WE_RF, WE_MEM, MEM_TO_REG, ILLEGAL;

  add_sub_control_unit #(.ADDR_W(AW), .PC_RESET(PCR)) dut (
    .CLK(CLK), .RST_N(RST_N), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .rs1(rs1), .rs2(rs2), .rd(rd),
    .immediate(immediate), .sub(sub), .I_type(I_type), .R_type(R_type), .WE_RF(WE_RF),
    .WE_MEM(WE_MEM), .MEM_TO_REG(MEM_TO_REG), .ILLEGAL(ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [31:0]   mem [64];
  int            m_ph;
  logic [AW-1:0] m_pc;
  logic [31:0]   m_word;

  typedef struct packed {
    logic        legal;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic        sub, i, r, we_rf, we_mem, m2r;
  } dec_t;

  // What the datapath must see for one instruction word.
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    int kind;
    d = '0;
    kind = 0;
    if (w[6:0] == 7'b0000011 && w[14:12] == 3'b011) kind = 1;
    else if (w[6:0] == 7'b0100011 && w[14:12] == 3'b011) kind = 2;
    else if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0000000) kind = 3;
    else if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0100000) kind = 4;
`ifdef ADD_SUB_ADDI_EN
    else if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) kind = 5;
`endif
    case (kind)
      1: begin
        d.legal = 1; d.rs1 = w[19:15]; d.rd = w[11:7]; d.imm = w[31:20];
        d.i = 1; d.m2r = 1; d.we_rf = (d.rd != 0);
      end
      2: begin
        d.legal = 1; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.imm = {w[31:25], w[11:7]};
        d.i = 1; d.we_mem = 1;
      end
      3, 4: begin
        d.legal = 1; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
        d.r = 1; d.sub = (kind == 4); d.we_rf = (d.rd != 0);
      end
      5: begin
        d.legal = 1; d.rs1 = w[19:15]; d.rd = w[11:7]; d.imm = w[31:20];
        d.i = 1; d.we_rf = (d.rd != 0);
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [66:0] expected();
    dec_t s;
    s = '0;
    if (m_ph == P_DEC || m_ph == P_EXE) s = decode(m_word);
    if (m_ph != P_EXE) begin
      s.we_rf = 0;
      s.we_mem = 0;
    end
    return {m_ph == P_FETCH, m_pc, s.rs1, s.rs2, s.rd, s.imm, s.sub, s.i, s.r,
            s.we_rf, s.we_mem, s.m2r, m_ph == P_TRAP};
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic cyc(input logic r, input logic a);
    logic [31:0] w;
    RST_N = r;
    IMEM_ACK = a;
    w = mem[IMEM_ADDR[7:2]];
    IMEM_RDATA = w;
    @(posedge CLK);
    if (!r) begin
      m_pc = PCR; m_ph = P_FETCH; m_word = '0;
    end else begin
      case (m_ph)
        P_FETCH: if (a) begin m_word = w; m_ph = P_DEC; end
        P_DEC:   m_ph = decode(m_word).legal ? P_EXE : P_TRAP;
        P_EXE:   begin m_pc = m_pc + 4; m_ph = P_FETCH; end
        default: ;
      endcase
    end
    @(negedge CLK);
    chk("cycle", {IMEM_REQ, IMEM_ADDR, rs1, rs2, rd, immediate, sub, I_type, R_type,
                  WE_RF, WE_MEM, MEM_TO_REG, ILLEGAL}, expected());
  endtask

  function automatic logic [31:0] gen_insn();
    logic [4:0]  ra, rb, rc;
    logic [11:0] im;
    int k;
    ra = 5'($urandom); rb = 5'($urandom); rc = 5'($urandom); im = 12'($urandom);
    k = $urandom_range(0, 99);
    if (k < 22)      return {im, ra, 3'b011, rc, 7'b0000011};
    else if (k < 44) return {im[11:5], rb, ra, 3'b011, im[4:0], 7'b0100011};
    else if (k < 66) return {7'b0000000, rb, ra, 3'b000, rc, 7'b0110011};
    else if (k < 88) return {7'b0100000, rb, ra, 3'b000, rc, 7'b0110011};
    else if (k < 93) return {im, ra, 3'b000, rc, 7'b0010011};
    else if (k < 95) return {7'b0000001, rb, ra, 3'b000, rc, 7'b0110011};
    else if (k < 97) return {im, ra, 3'b010, rc, 7'b0000011};
    else             return $urandom;
  endfunction

  initial begin
    RST_N = 1'b0; IMEM_ACK = 1'b0; IMEM_RDATA = '0;
    m_ph = P_FETCH; m_pc = PCR; m_word = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset taken in the middle of an add's execute cycle.
    mem[0] = 32'h00508533;
    cyc(0, 0); cyc(0, 0);
    cyc(1, 1);
    cyc(1, 0);
    chk("t1_we_rf_exec", 67'(WE_RF), 67'd1);
    cyc(0, 0); cyc(0, 0);
    chk("t1_we_rf_reset", 67'(WE_RF), 67'd0);
    chk("t1_addr_reset", 67'(IMEM_ADDR), 67'(PCR));
    chk("t1_req_reset", 67'(IMEM_REQ), 67'd1);

    // ld, sd, then an illegal word at PC=8.
    mem[0] = 32'h01003083; mem[1] = 32'h00103A23; mem[2] = 32'hFFFFFFFF;
    cyc(1, 1);
    chk("t2_rd", 67'(rd), 67'd1);
    chk("t2_imm", 67'(immediate), 67'd16);
    chk("t2_itype", 67'(I_type), 67'd1);
    cyc(1, 0);
    chk("t2_we_rf", 67'(WE_RF), 67'd1);
    chk("t2_mem_to_reg", 67'(MEM_TO_REG), 67'd1);
    cyc(1, 0);
    chk("t2_pc", 67'(IMEM_ADDR), 67'd4);
    chk("t2_we_rf_drop", 67'(WE_RF), 67'd0);
    cyc(1, 1);
    chk("t3_rs2", 67'(rs2), 67'd1);
    chk("t3_rs1", 67'(rs1), 67'd0);
    chk("t3_imm", 67'(immediate), 67'd20);
    cyc(1, 0);
    chk("t3_we_mem", 67'(WE_MEM), 67'd1);
    chk("t3_we_rf", 67'(WE_RF), 67'd0);
    cyc(1, 0);
    chk("t3_we_mem_drop", 67'(WE_MEM), 67'd0);
    cyc(1, 1); cyc(1, 0);
    chk("t6_illegal", 67'(ILLEGAL), 67'd1);
    for (int i = 0; i < 3; i++) cyc(1, 1);
    chk("t6_pc_frozen", 67'(IMEM_ADDR), 67'd8);
    chk("t6_no_req", 67'(IMEM_REQ), 67'd0);

    // Delayed ack, stray ack in decode, sub then add, then addi.
    mem[0] = 32'h40B28A33; mem[1] = 32'h00508533; mem[2] = 32'h00500193;
    cyc(0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0);
      chk("t5_req_held", 67'({IMEM_REQ, IMEM_ADDR, WE_RF, WE_MEM}), 67'({1'b1, 32'd0, 2'b00}));
    end
    cyc(1, 1);
    chk("t4_sub", 67'({sub, R_type, rd}), 67'({1'b1, 1'b1, 5'd20}));
    cyc(1, 1);
    chk("t5_stray_ack", 67'({WE_RF, IMEM_ADDR}), 67'({1'b1, 32'd0}));
    cyc(1, 0);
    cyc(1, 1);
    chk("t4_add", 67'({sub, R_type, rd}), 67'({1'b0, 1'b1, 5'd10}));
    cyc(1, 0); cyc(1, 0); cyc(1, 1);
`ifdef ADD_SUB_ADDI_EN
    chk("t6_addi_imm", 67'({immediate, MEM_TO_REG}), 67'({12'd5, 1'b0}));
    cyc(1, 0);
    chk("t6_addi_we", 67'(WE_RF), 67'd1);
`else
    cyc(1, 0);
    chk("t6_addi_trap", 67'(ILLEGAL), 67'd1);
`endif

    // Randomized program with random ack timing and occasional resets.
    for (int i = 0; i < 64; i++) mem[i] = gen_insn();
    cyc(0, 0);
    for (int n = 0; n < 4000; n++) begin
      logic r, a;
      if (m_ph == P_TRAP) r = ($urandom_range(0, 3) != 0);
      else                r = ($urandom_range(0, 99) != 0);
      if (m_ph == P_FETCH) a = ($urandom_range(0, 1) == 1);
      else                 a = ($urandom_range(0, 3) == 0);
      cyc(r, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
